im_ctrl: RTL and testbench

Parametrised instruction memory with a synchronous, handshaked fetch port and a sequential program-load port. It sits between the CPU fetch stage and the instruction store. A host or loader can write a program into the block at run time, then release it to the CPU without re-elaborating the design. Read latency is one cycle, throughput is one word per cycle, and out-of-range fetches return a NOP and raise an error flag.

---
 rtl/im_ctrl.sv | 132 +++++++++++++
 tb/tb_im_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_ctrl.sv
// Instruction memory with a one-cycle handshaked fetch port and a sequential
// program-load port; out-of-range fetches return a NOP with an error flag.
module im_ctrl #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 128,
  parameter int    ADDR_W    = 30,
  parameter int    PTR_W     = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic [PTR_W-1:0]  load_base,
  input  logic              load_we,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              loading,
  output logic [PTR_W-1:0]  load_ptr,
  output logic              load_ovf
);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_SIZE = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  load_ptr_q, load_ptr_d;
  logic              load_ovf_q, load_ovf_d;
  logic              end_q, end_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic              mem_we;
  logic              addr_oob;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign addr_oob = (fetch_addr >= ADDR_SIZE);

  always_comb begin
    state_d       = state_q;
    load_ptr_d    = load_ptr_q;
    load_ovf_d    = load_ovf_q;
    end_d         = end_q;
    fetch_valid_d = 1'b0;
    fetch_err_d   = fetch_err_q;
    fetch_data_d  = fetch_data_q;
    mem_we        = 1'b0;

    // Fetches are accepted only in IDLE, including the cycle that starts a load.
    if (state_q == S_IDLE && fetch_req) begin
      fetch_valid_d = 1'b1;
      fetch_err_d   = addr_oob;
      fetch_data_d  = addr_oob ? '0 : mem[fetch_addr[PTR_W-1:0]];
    end

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d    = S_LOAD;
          load_ptr_d = load_base;
          load_ovf_d = 1'b0;
          end_d      = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          load_ptr_d = load_base;
          load_ovf_d = 1'b0;
          end_d      = 1'b0;
        end else begin
          // Once the last word has been written, further writes are dropped.
          if (load_we) begin
            if (end_q) begin
              load_ovf_d = 1'b1;
            end else begin
              mem_we = 1'b1;
              if (load_ptr_q == PTR_LAST) end_d = 1'b1;
              else                        load_ptr_d = load_ptr_q + 1'b1;
            end
          end
          if (load_done) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      load_ptr_q    <= '0;
      load_ovf_q    <= 1'b0;
      end_q         <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      load_ptr_q    <= load_ptr_d;
      load_ovf_q    <= load_ovf_d;
      end_q         <= end_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      fetch_data_q  <= fetch_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem[load_ptr_q] <= load_data;
  end

  assign fetch_ready = (state_q == S_IDLE);
  assign loading     = (state_q == S_LOAD);
  assign load_ptr    = load_ptr_q;
  assign load_ovf    = load_ovf_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_err   = fetch_err_q;
  assign fetch_data  = fetch_data_q;

endmodule

// File: tb/tb_im_ctrl.sv
// Randomised self-checking bench for im_ctrl against an array-based model of
// the store and arithmetic predictions of the load pointer and overflow flag.
module tb_im_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 30;
  localparam int PTR_W  = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;
  logic              load_start;
  logic [PTR_W-1:0]  load_base;
  logic              load_we;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              loading;
  logic [PTR_W-1:0]  load_ptr;
  logic              load_ovf;

  im_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .load_start(load_start), .load_base(load_base), .load_we(load_we),
    .load_data(load_data), .load_done(load_done), .loading(loading),
    .load_ptr(load_ptr), .load_ovf(load_ovf)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [DATA_W-1:0] mdl_mem [DEPTH];
  logic [DATA_W-1:0] wq[$];
  logic [ADDR_W-1:0] fq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W:0] exp_resp(input logic [ADDR_W-1:0] a);
    if (a >= ADDR_W'(DEPTH)) return {1'b1, {DATA_W{1'b0}}};
    return {1'b0, mdl_mem[a[PTR_W-1:0]]};
  endfunction

  // Drive the queued addresses back-to-back and check each in-order response.
  task automatic run_fetches();
    logic [DATA_W:0] last;
    last = '0;
    while (fq.size() > 0) begin
      fetch_addr = fq.pop_front();
      fetch_req  = 1'b1;
      chk_cnt++;
      if (fetch_ready !== 1'b1) $display("FAIL fetch_ready: got %b want 1", fetch_ready);
      else pass_cnt++;
      tick();
      last = exp_resp(fetch_addr);
      chk_cnt++;
      if ({fetch_valid, fetch_err, fetch_data} !== {1'b1, last})
        $display("FAIL fetch addr=%0d: got v=%b e=%b d=%h want v=1 e=%b d=%h",
                 fetch_addr, fetch_valid, fetch_err, fetch_data, last[DATA_W], last[DATA_W-1:0]);
      else pass_cnt++;
    end
    fetch_req = 1'b0;
    tick();
    chk_cnt++;
    if ({fetch_valid, fetch_err, fetch_data} !== {1'b0, last})
      $display("FAIL fetch_hold: got v=%b e=%b d=%h want v=0 e=%b d=%h",
               fetch_valid, fetch_err, fetch_data, last[DATA_W], last[DATA_W-1:0]);
    else pass_cnt++;
  endtask

  // Full load session: start at base, write the queued words (random data if
  // the queue runs dry) with random idle gaps, check pointer/overflow, finish.
  task automatic do_load(input int base, input int n);
    logic [DATA_W-1:0] w;
    int exp_ptr;
    load_start = 1'b1; load_base = PTR_W'(base);
    tick();
    load_start = 1'b0;
    chk_cnt++;
    if ({loading, load_ptr, load_ovf} !== {1'b1, PTR_W'(base), 1'b0})
      $display("FAIL load_enter: got loading=%b ptr=%0d ovf=%b want 1 %0d 0", loading, load_ptr, load_ovf, base);
    else pass_cnt++;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      w = (wq.size() > 0) ? wq.pop_front() : DATA_W'($urandom);
      load_we = 1'b1; load_data = w;
      tick();
      load_we = 1'b0;
      if (base + i < DEPTH) mdl_mem[base + i] = w;
    end
    exp_ptr = (base + n > DEPTH - 1) ? DEPTH - 1 : base + n;
    chk_cnt++;
    if ({load_ptr, load_ovf} !== {PTR_W'(exp_ptr), (base + n > DEPTH)})
      $display("FAIL load_ptr_ovf: got ptr=%0d ovf=%b want ptr=%0d ovf=%b",
               load_ptr, load_ovf, exp_ptr, (base + n > DEPTH));
    else pass_cnt++;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk_cnt++;
    if (loading !== 1'b0) $display("FAIL load_exit: got loading=%b want 0", loading);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0;
    load_base = '0; load_we = 1'b0; load_data = '0; load_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    tick(); tick();
    chk_cnt++;
    if ({fetch_valid, fetch_err, fetch_data, loading, load_ptr, load_ovf, fetch_ready} !== {1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b1})
      $display("FAIL reset_state: got v=%b e=%b d=%h ld=%b ptr=%0d ovf=%b rdy=%b want 0 0 0 0 0 0 1",
               fetch_valid, fetch_err, fetch_data, loading, load_ptr, load_ovf, fetch_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_init_zero();
    fq.push_back(0); fq.push_back(1);
    run_fetches();
  endtask

  task automatic test_program_load();
    wq.push_back(32'h34010004); wq.push_back(32'h34020001); wq.push_back(32'h00431021);
    do_load(0, 3);
    chk_cnt++;
    if (load_ptr !== 7'd3) $display("FAIL prog_ptr: got %0d want 3", load_ptr);
    else pass_cnt++;
    fq.push_back(0); fq.push_back(1); fq.push_back(2);
    run_fetches();
  endtask

  task automatic test_oob();
    fq.push_back(200);
    fq.push_back(128);
    fq.push_back(ADDR_W'($urandom_range(129, 30'h3FFF_FFFF)));
    fq.push_back(30'h3FFF_FFFF);
    fq.push_back(200 % DEPTH);
    fq.push_back(127);
    run_fetches();
  endtask

  task automatic test_overflow();
    wq.push_back(32'hAAAA0001); wq.push_back(32'hAAAA0002); wq.push_back(32'hAAAA0003);
    load_start = 1'b1; load_base = 7'd126;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_we = 1'b1; load_data = wq.pop_front();
      tick();
    end
    load_we = 1'b0;
    mdl_mem[126] = 32'hAAAA0001; mdl_mem[127] = 32'hAAAA0002;
    chk_cnt++;
    if ({load_ovf, load_ptr} !== {1'b1, 7'd127})
      $display("FAIL ovf_set: got ovf=%b ptr=%0d want 1 127", load_ovf, load_ptr);
    else pass_cnt++;
    // Restart at the last word: the write must land again, not be dropped.
    load_start = 1'b1; load_base = 7'd127;
    tick();
    load_start = 1'b0;
    chk_cnt++;
    if ({load_ovf, load_ptr, loading} !== {1'b0, 7'd127, 1'b1})
      $display("FAIL ovf_restart: got ovf=%b ptr=%0d ld=%b want 0 127 1", load_ovf, load_ptr, loading);
    else pass_cnt++;
    load_we = 1'b1; load_data = 32'hBBBB0127;
    tick();
    load_we = 1'b0;
    mdl_mem[127] = 32'hBBBB0127;
    chk_cnt++;
    if ({load_ovf, load_ptr} !== {1'b0, 7'd127})
      $display("FAIL ovf_after_restart: got ovf=%b ptr=%0d want 0 127", load_ovf, load_ptr);
    else pass_cnt++;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    fq.push_back(126); fq.push_back(127); fq.push_back(0); fq.push_back(1);
    run_fetches();
  endtask

  task automatic test_fetch_blocked();
    logic [DATA_W-1:0] w;
    w = DATA_W'($urandom);
    load_start = 1'b1; load_base = 7'd10;
    tick();
    load_start = 1'b0;
    fetch_req = 1'b1; fetch_addr = 10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++;
      if ({fetch_ready, fetch_valid} !== 2'b00)
        $display("FAIL blocked_fetch: got rdy=%b v=%b want 0 0", fetch_ready, fetch_valid);
      else pass_cnt++;
    end
    load_we = 1'b1; load_done = 1'b1; load_data = w;
    tick();
    load_we = 1'b0; load_done = 1'b0;
    mdl_mem[10] = w;
    chk_cnt++;
    if ({loading, load_ptr, fetch_valid} !== {1'b0, 7'd11, 1'b0})
      $display("FAIL we_with_done: got ld=%b ptr=%0d v=%b want 0 11 0", loading, load_ptr, fetch_valid);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({fetch_valid, fetch_err, fetch_data} !== {1'b1, 1'b0, w})
      $display("FAIL first_idle_fetch: got v=%b e=%b d=%h want 1 0 %h", fetch_valid, fetch_err, fetch_data, w);
    else pass_cnt++;
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_fetch_into_load();
    logic [DATA_W:0] e;
    fetch_req = 1'b1; fetch_addr = 126; load_start = 1'b1; load_base = 7'd50;
    e = exp_resp(126);
    tick();
    fetch_req = 1'b0; load_start = 1'b0;
    chk_cnt++;
    if ({fetch_valid, fetch_err, fetch_data, loading, load_ptr} !== {1'b1, e, 1'b1, 7'd50})
      $display("FAIL fetch_into_load: got v=%b e=%b d=%h ld=%b ptr=%0d want 1 %b %h 1 50",
               fetch_valid, fetch_err, fetch_data, loading, load_ptr, e[DATA_W], e[DATA_W-1:0]);
    else pass_cnt++;
    // load_start beats load_done in the same cycle.
    load_start = 1'b1; load_done = 1'b1; load_base = 7'd60;
    tick();
    load_start = 1'b0; load_done = 1'b0;
    chk_cnt++;
    if ({loading, load_ptr} !== {1'b1, 7'd60})
      $display("FAIL start_beats_done: got ld=%b ptr=%0d want 1 60", loading, load_ptr);
    else pass_cnt++;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic test_reset_midload();
    logic [DATA_W-1:0] w0, w1;
    w0 = DATA_W'($urandom); w1 = DATA_W'($urandom);
    load_start = 1'b1; load_base = 7'd40;
    tick();
    load_start = 1'b0;
    load_we = 1'b1; load_data = w0; tick();
    load_data = w1; tick();
    load_we = 1'b0;
    mdl_mem[40] = w0; mdl_mem[41] = w1;
    rst_n = 1'b0;
    tick();
    chk_cnt++;
    if ({fetch_valid, fetch_err, fetch_data, loading, load_ptr, load_ovf} !== {1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0})
      $display("FAIL midload_reset: got v=%b e=%b d=%h ld=%b ptr=%0d ovf=%b want all 0",
               fetch_valid, fetch_err, fetch_data, loading, load_ptr, load_ovf);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    fq.push_back(40); fq.push_back(41);
    run_fetches();
  endtask

  task automatic test_random();
    int base, n;
    for (int it = 0; it < 8; it++) begin
      base = $urandom_range(0, DEPTH - 1);
      n    = $urandom_range(1, 6);
      do_load(base, n);
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 3))
          0:       fq.push_back(ADDR_W'($urandom_range(DEPTH, 30'h3FFF_FFFF)));
          1:       fq.push_back(ADDR_W'($urandom_range(0, DEPTH - 1)));
          default: fq.push_back(ADDR_W'((base + $urandom_range(0, n - 1)) % DEPTH));
        endcase
      end
      run_fetches();
    end
  endtask

  initial begin
    test_reset();
    test_init_zero();
    test_program_load();
    test_oob();
    test_overflow();
    test_fetch_blocked();
    test_fetch_into_load();
    test_reset_midload();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
